// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Define MD_DIVZERO_EN for a 1-cycle divide-by-zero that leaves HI/LO untouched.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] mdA,
  input  logic [31:0] mdB,
  input  logic [1:0]  mdRead,
  output logic        busy,
  output logic        mdStall,
  output logic [31:0] mdOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntLoad;
  logic [2:0]       opReg;
  logic [31:0]      aReg, bReg, hiReg, loReg;
  logic [31:0]      hiRes, loRes;
  logic             isArith, isDivOp, accept, done;

  assign isArith = start && (mdOp >= OP_MULT) && (mdOp <= OP_DIVU);
  assign isDivOp = (mdOp == OP_DIV) || (mdOp == OP_DIVU);
  assign accept  = (stateReg == IDLE) && isArith;
  assign done    = (stateReg == BUSY) && (cntReg == '0);
  assign busy    = (stateReg == BUSY);
  assign mdStall = busy || isArith;

  always_comb begin
    mdOut = 32'd0;
    case (mdRead)
      2'b01:   mdOut = hiReg;
      2'b10:   mdOut = loReg;
      default: mdOut = 32'd0;
    endcase
  end

  always_comb begin
    cntLoad = isDivOp ? DIV_LOAD : MULT_LOAD;
`ifdef MD_DIVZERO_EN
    if (isDivOp && (mdB == 32'd0))
      cntLoad = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset)
      stateReg <= IDLE;
    else
      stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (accept) stateNext = BUSY;
      BUSY:    if (done) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Results come from the latched operands; they only reach HI/LO on completion.
  logic [63:0] sProd, uProd;
  logic [31:0] divisor, absA, absB, absDiv, magQ, magR;

  always_comb begin
    sProd   = {{32{aReg[31]}}, aReg} * {{32{bReg[31]}}, bReg};
    uProd   = {32'd0, aReg} * {32'd0, bReg};
    divisor = (bReg == 32'd0) ? 32'd1 : bReg;
    absA    = aReg[31] ? -aReg : aReg;
    absB    = bReg[31] ? -bReg : bReg;
    absDiv  = (absB == 32'd0) ? 32'd1 : absB;
    // Magnitude division keeps 0x8000_0000 / -1 well defined (quotient wraps to itself).
    magQ    = absA / absDiv;
    magR    = absA % absDiv;
    hiRes   = hiReg;
    loRes   = loReg;
    case (opReg)
      OP_MULT:  {hiRes, loRes} = sProd;
      OP_MULTU: {hiRes, loRes} = uProd;
      OP_DIV, OP_DIVU: begin
        if (bReg == 32'd0) begin
`ifndef MD_DIVZERO_EN
          hiRes = aReg;
          loRes = 32'hFFFF_FFFF;
`endif
        end else if (opReg == OP_DIV) begin
          loRes = (aReg[31] ^ bReg[31]) ? -magQ : magQ;
          hiRes = aReg[31] ? -magR : magR;
        end else begin
          loRes = aReg / divisor;
          hiRes = aReg % divisor;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cntReg <= '0;
      opReg  <= 3'd0;
      aReg   <= 32'd0;
      bReg   <= 32'd0;
      hiReg  <= 32'd0;
      loReg  <= 32'd0;
    end else begin
      if (accept) begin
        aReg   <= mdA;
        bReg   <= mdB;
        opReg  <= mdOp;
        cntReg <= cntLoad;
      end else if (busy && (cntReg != '0)) begin
        cntReg <= cntReg - CNT_W'(1);
      end
      if (done) begin
        hiReg <= hiRes;
        loReg <= loRes;
      end else if ((stateReg == IDLE) && start) begin
        if (mdOp == OP_MTHI) hiReg <= mdA;
        if (mdOp == OP_MTLO) loReg <= mdA;
      end
    end
  end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide controller for the execute stage. It sequences a multi-cycle multiply/divide operation on operands captured from the E-stage ALU inputs, and owns the architectural HI/LO registers. It exposes `busy` so the hazard unit can stall D-stage HI/LO consumers, and it drives `mdOut` with HI or LO for `mfhi`/`mflo`.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).

Ports:
- `clk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: E-stage instruction is an md op this cycle (qualifies `mdOp`).
- `mdOp` in 3: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
- `mdA` in 32: rs operand (dividend / multiplicand / mthi, mtlo source).
- `mdB` in 32: rt operand (divisor / multiplier).
- `mdRead` in 2: 00 none, 01 HI, 10 LO, 11 none.
- `busy` out 1: operation in flight.
- `mdStall` out 1: combinational `busy | (start & mdOp in {001..100})`. D-stage md/mf instruction must stall.
- `mdOut` out 32: combinational HI when `mdRead`=01, LO when 10, else 0.

## Operation
- States: IDLE, BUSY. `cnt` down-counter sized for max(`MULT_CYCLES`,`DIV_CYCLES`).
- IDLE & `start` & op in {mult,multu,div,divu}: latch `mdA`/`mdB`/op, load `cnt` with N−1 (N = `MULT_CYCLES` or `DIV_CYCLES`), go BUSY.
- BUSY: decrement `cnt`. When `cnt`=0: write HI/LO, go IDLE.
- IDLE & `start` & mthi: HI←`mdA` at this edge. mtlo: LO←`mdA`. Both take no busy cycles.
- `start` while BUSY: ignored entirely (no latch, no HI/LO write). The hazard unit guarantees this does not occur; the block must still be safe.
- mult: {HI,LO} ← signed(A)×signed(B), 64-bit. multu: unsigned 64-bit product.
- div: LO ← quotient truncated toward zero, HI ← remainder with the dividend's sign.
  - 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero: see Configuration.
- HI/LO change only at operation completion or at mthi/mtlo. `mdOut` always reflects the committed registers and never partial results.
- Reset mid-operation: state→IDLE, `cnt`←0, HI←0, LO←0. The in-flight result is discarded.

## Timing
- Reset values: `busy`=0, `mdStall`=0 (absent `start`), `mdOut`=0, HI=LO=0, state IDLE.
- Start accepted at edge of cycle T. `busy`=1 in cycles T+1..T+N. HI/LO written at edge ending T+N. `busy`=0 and new value on `mdOut` in T+N+1.
- Back-to-back: a `start` in cycle T+N+1 is accepted (one idle cycle minimum between ops is not required beyond `busy` deassertion).
- mthi/mtlo in cycle T: `mdOut` shows the new value in T+1.
- `start` with mdOp none/111: no effect, `mdStall` not asserted by it.

## Configuration
- `MD_DIVZERO_EN` defined:
  - div/divu with B=0 completes in 1 busy cycle (N=1 regardless of `DIV_CYCLES`).
  - HI, LO left unchanged.
- `MD_DIVZERO_EN` undefined:
  - Divide by zero takes the full `DIV_CYCLES`.
  - Writes LO=0xFFFF_FFFF and HI=A (both div and divu).
  - The result is deterministic; X is never produced.

## Test plan
- mult A=0xFFFF_FFFE(−2), B=3 at T → `busy` T+1..T+5; at T+6 HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; multu same operands → HI=0x0000_0002, LO=0xFFFF_FFFA.
- div A=−7 (0xFFFF_FFF9), B=2 → after 10 busy cycles LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; divu 7/2 → LO=3, HI=1; div 0x8000_0000/0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- mthi 0x1234_5678, then mtlo 0xCAFE_0000 on next cycle → `mdRead`=01 gives 0x1234_5678, 10 gives 0xCAFE_0000; `busy` never rises.
- div in flight, second `start` mult at busy cycle 3 → ignored; final HI/LO equal the div result; `busy` falls exactly after 10 cycles.
- reset asserted at busy cycle 4 of a mult → next cycle `busy`=0, HI=LO=0; no later write occurs.
- div 5/0 → with `MD_DIVZERO_EN`: 1 busy cycle, HI/LO unchanged; without: 10 busy cycles, LO=0xFFFF_FFFF, HI=5.
